mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter; data wins over fetch (ARB_STARVE_GUARD_EN adds a fetch starvation guard).
// Latency: req to ack 3 cycles minimum (IDLE grant, SERVE until mem_ready, RESP ack pulse).
// Backpressure: losing/busy requests stay pending untouched; mem_ready stretches SERVE indefinitely.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_IF = 2'd1,
        SERVE_D  = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IF   = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    state_t      state;
    state_t      state_nxt;
    logic        grant_if;
    logic        grant_d;
    logic        starve_hit;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  owner_q;

`ifdef ARB_STARVE_GUARD_EN
    // Counts back-to-back data grants that overtook a waiting fetch.
    logic [1:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 2'd0;
        end else if (grant_if) begin
            starve_cnt <= 2'd0;
        end else if (grant_d && if_req && (starve_cnt != 2'd3)) begin
            starve_cnt <= starve_cnt + 2'd1;
        end
    end

    assign starve_hit = (starve_cnt == 2'd3);
`else
    assign starve_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !(if_req && starve_hit)) begin
                    grant_d   = 1'b1;
                    state_nxt = SERVE_D;
                end else if (if_req) begin
                    grant_if  = 1'b1;
                    state_nxt = SERVE_IF;
                end
            end
            SERVE_IF, SERVE_D: begin
                if (mem_ready) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request is latched at grant so the RAM sees a stable command even if the requester misbehaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            we_q     <= 1'b0;
            owner_q  <= OWN_NONE;
            if_rdata <= 32'd0;
            d_rdata  <= 32'd0;
        end else begin
            if (grant_d) begin
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
                we_q    <= d_we;
                owner_q <= OWN_D;
            end else if (grant_if) begin
                addr_q  <= if_addr;
                wdata_q <= 32'd0;
                we_q    <= 1'b0;
                owner_q <= OWN_IF;
            end
            if ((state == SERVE_IF) && mem_ready) begin
                if_rdata <= mem_rdata;
            end
            if ((state == SERVE_D) && mem_ready) begin
                d_rdata <= mem_rdata;
            end
            if (state == RESP) begin
                owner_q <= OWN_NONE;
                we_q    <= 1'b0;
            end
        end
    end

    assign mem_en    = (state == SERVE_IF) || (state == SERVE_D);
    assign mem_we    = we_q && mem_en;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign owner     = owner_q;
    assign if_ack    = (state == RESP) && (owner_q == OWN_IF);
    assign d_ack     = (state == RESP) && (owner_q == OWN_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-scenario tasks, RAM responder and per-port ack scoreboards.
// Build with ARB_STARVE_GUARD_EN defined to expect the guarded grant order.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;
    logic [1:0]  owner;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_if_q[$];
    logic [31:0] exp_d_q[$];
    bit          grant_log[$];   // 1 = fetch ack, 0 = data ack
    bit          if_auto = 1'b0;
    bit          d_auto = 1'b0;
    bit          resp_en = 1'b1;
    int          ready_delay = 0;
    int          wait_cnt = 0;
    logic [31:0] mon_e;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .owner(owner)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h2001_000A;
        return {a[15:0], ~a[15:0]};
    endfunction

    // RAM model: answers after ready_delay idle SERVE cycles.
    always @(negedge clk) begin
        if (resp_en) begin
            mem_ready = 1'b0;
            if (mem_en) begin
                if (wait_cnt >= ready_delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    wait_cnt  = 0;
                end else begin
                    wait_cnt = wait_cnt + 1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Requester side: check each ack against its port's queue, then drop or reissue the request.
    always @(negedge clk) begin
        if (if_ack && d_ack) begin
            n_cmp++; n_bad++;
            $display("FAIL dual_ack: if_ack=%b d_ack=%b, required at most one", if_ack, d_ack);
        end
        if (if_ack) begin
            n_cmp++;
            if (exp_if_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_if: unexpected if_ack, rdata %h", if_rdata);
            end else begin
                mon_e = exp_if_q.pop_front();
                if (if_rdata !== mon_e) begin
                    n_bad++;
                    $display("FAIL sb_if: if_rdata %h, required %h", if_rdata, mon_e);
                end
            end
            grant_log.push_back(1'b1);
            if (if_auto) exp_if_q.push_back(mem_word(if_addr));
            else if_req = 1'b0;
        end
        if (d_ack) begin
            n_cmp++;
            if (exp_d_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_d: unexpected d_ack, rdata %h", d_rdata);
            end else begin
                mon_e = exp_d_q.pop_front();
                if (d_rdata !== mon_e) begin
                    n_bad++;
                    $display("FAIL sb_d: d_rdata %h, required %h", d_rdata, mon_e);
                end
            end
            grant_log.push_back(1'b0);
            if (d_auto) exp_d_q.push_back(mem_word(d_addr));
            else d_req = 1'b0;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (owner !== 2'b00) begin n_bad++; $display("FAIL rst_owner: %b, required 00", owner); end
        n_cmp++; if ({if_ack, d_ack, mem_en, mem_we} !== 4'b0000) begin
            n_bad++; $display("FAIL rst_strobes: %b, required 0000", {if_ack, d_ack, mem_en, mem_we});
        end
        n_cmp++; if ({mem_addr, mem_wdata} !== 64'd0) begin
            n_bad++; $display("FAIL rst_mem_bus: addr %h wdata %h, required 0", mem_addr, mem_wdata);
        end
        n_cmp++; if ({if_rdata, d_rdata} !== 64'd0) begin
            n_bad++; $display("FAIL rst_rdata: if %h d %h, required 0", if_rdata, d_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        @(negedge clk);
        ready_delay = 0;
        if_addr = 32'h0000_0040;
        if_req  = 1'b1;
        exp_if_q.push_back(32'h2001_000A);
        n_cmp++; if (owner !== 2'b00 || mem_en !== 1'b0) begin
            n_bad++; $display("FAIL sf_c1: owner %b mem_en %b, required 00/0", owner, mem_en);
        end
        @(negedge clk);
        n_cmp++; if (owner !== 2'b01) begin n_bad++; $display("FAIL sf_c2_owner: %b, required 01", owner); end
        n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) begin
            n_bad++; $display("FAIL sf_c2_bus: en %b we %b addr %h, required 1/0/00000040", mem_en, mem_we, mem_addr);
        end
        n_cmp++; if (if_ack !== 1'b0) begin n_bad++; $display("FAIL sf_c2_ack: %b, required 0", if_ack); end
        @(negedge clk);
        n_cmp++; if (if_ack !== 1'b1 || if_rdata !== 32'h2001_000A) begin
            n_bad++; $display("FAIL sf_c3_ack: ack %b rdata %h, required 1/2001000a", if_ack, if_rdata);
        end
        n_cmp++; if (owner !== 2'b01 || mem_en !== 1'b0) begin
            n_bad++; $display("FAIL sf_c3_state: owner %b mem_en %b, required 01/0", owner, mem_en);
        end
        @(negedge clk);
        n_cmp++; if (owner !== 2'b00 || if_ack !== 1'b0 || if_rdata !== 32'h2001_000A) begin
            n_bad++; $display("FAIL sf_c4_idle: owner %b ack %b rdata %h, required 00/0/2001000a", owner, if_ack, if_rdata);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        grant_log.delete();
        d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
        if_addr = 32'h0000_0080;
        exp_d_q.push_back(mem_word(32'h100));
        exp_if_q.push_back(mem_word(32'h80));
        d_req = 1'b1; if_req = 1'b1;
        @(negedge clk);
        n_cmp++; if (owner !== 2'b10 || mem_en !== 1'b1 || mem_we !== 1'b1) begin
            n_bad++; $display("FAIL sim_serve_d: owner %b en %b we %b, required 10/1/1", owner, mem_en, mem_we);
        end
        n_cmp++; if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL sim_bus_d: addr %h wdata %h, required 00000100/deadbeef", mem_addr, mem_wdata);
        end
        @(negedge clk);
        n_cmp++; if (d_ack !== 1'b1 || if_ack !== 1'b0) begin
            n_bad++; $display("FAIL sim_resp_d: d_ack %b if_ack %b, required 1/0", d_ack, if_ack);
        end
        n_cmp++; if (if_rdata !== 32'h2001_000A) begin
            n_bad++; $display("FAIL sim_if_hold: if_rdata %h, required 2001000a", if_rdata);
        end
        repeat (2) @(negedge clk);
        n_cmp++; if (owner !== 2'b01 || mem_addr !== 32'h80 || mem_we !== 1'b0) begin
            n_bad++; $display("FAIL sim_serve_if: owner %b addr %h we %b, required 01/00000080/0", owner, mem_addr, mem_we);
        end
        @(negedge clk);
        n_cmp++; if (if_ack !== 1'b1) begin n_bad++; $display("FAIL sim_resp_if: if_ack %b, required 1", if_ack); end
        @(negedge clk);
        n_cmp++; if (grant_log.size() != 2 || exp_if_q.size() != 0 || exp_d_q.size() != 0) begin
            n_bad++; $display("FAIL sim_done: acks %0d pending %0d/%0d, required 2/0/0",
                              grant_log.size(), exp_if_q.size(), exp_d_q.size());
        end else begin
            n_cmp++; if (grant_log[0] !== 1'b0 || grant_log[1] !== 1'b1) begin
                n_bad++; $display("FAIL sim_order: %b%b, required data then fetch", grant_log[0], grant_log[1]);
            end
        end
    endtask

    task automatic test_variable_latency();
        int serve = 0;
        int acks = 0;
        bit stable = 1'b1;
        @(negedge clk);
        ready_delay = 5;
        d_we = 1'b0; d_addr = 32'h0000_0200;
        exp_d_q.push_back(mem_word(32'h200));
        d_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_en) begin
                serve++;
                if (mem_addr !== 32'h200 || mem_we !== 1'b0) stable = 1'b0;
            end
            if (d_ack) acks++;
        end
        ready_delay = 0;
        n_cmp++; if (serve != 6) begin n_bad++; $display("FAIL vl_serve_cycles: %0d, required 6", serve); end
        n_cmp++; if (!stable) begin n_bad++; $display("FAIL vl_stable: bus changed during SERVE, required stable"); end
        n_cmp++; if (acks != 1) begin n_bad++; $display("FAIL vl_ack_cycles: %0d, required 1", acks); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        resp_en = 1'b0;
        d_we = 1'b1; d_addr = 32'h0000_0300; d_wdata = 32'h1234_5678;
        d_req = 1'b1;
        @(negedge clk);
        n_cmp++; if (owner !== 2'b10 || mem_en !== 1'b1) begin
            n_bad++; $display("FAIL rm_serve: owner %b en %b, required 10/1", owner, mem_en);
        end
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        n_cmp++; if (owner !== 2'b00 || mem_en !== 1'b0 || d_ack !== 1'b0) begin
            n_bad++; $display("FAIL rm_after_rst: owner %b en %b ack %b, required 00/0/0", owner, mem_en, d_ack);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        n_cmp++; if (owner !== 2'b00 || mem_en !== 1'b0 || d_ack !== 1'b0) begin
            n_bad++; $display("FAIL rm_late_ready: owner %b en %b ack %b, required 00/0/0", owner, mem_en, d_ack);
        end
        n_cmp++; if (d_rdata !== 32'd0) begin n_bad++; $display("FAIL rm_rdata: %h, required 0", d_rdata); end
        @(negedge clk);
        n_cmp++; if (d_ack !== 1'b0 || mem_en !== 1'b0) begin
            n_bad++; $display("FAIL rm_idle: ack %b en %b, required 0/0", d_ack, mem_en);
        end
        resp_en = 1'b1;
    endtask

    task automatic test_starvation();
        logic [7:0] got;
        logic [7:0] want;
`ifdef ARB_STARVE_GUARD_EN
        want = 8'b1000_1000;   // bit i = grant i: D,D,D,IF,D,D,D,IF
`else
        want = 8'b0000_0000;
`endif
        @(negedge clk);
        grant_log.delete();
        if_auto = 1'b1; d_auto = 1'b1;
        if_addr = 32'h0000_0040; d_we = 1'b0; d_addr = 32'h0000_0500;
        exp_if_q.push_back(mem_word(32'h40));
        exp_d_q.push_back(mem_word(32'h500));
        if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 200 && grant_log.size() < 8; i++) @(negedge clk);
        if_auto = 1'b0; d_auto = 1'b0;
        n_cmp++;
        if (grant_log.size() < 8) begin
            n_bad++; $display("FAIL starve_timeout: %0d grants, required 8", grant_log.size());
        end else begin
            for (int i = 0; i < 8; i++) got[i] = grant_log[i];
            if (got !== want) begin
                n_bad++; $display("FAIL starve_order: %b, required %b (1=fetch, bit0 first)", got, want);
            end
        end
        for (int i = 0; i < 100 && (if_req || d_req); i++) @(negedge clk);
        n_cmp++; if (if_req || d_req || exp_if_q.size() != 0 || exp_d_q.size() != 0) begin
            n_bad++; $display("FAIL starve_drain: req %b%b pending %0d/%0d, required all served",
                              if_req, d_req, exp_if_q.size(), exp_d_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_variable_latency();
        test_reset_mid();
        test_starvation();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
